// File: rtl/byte_search_initiator.sv
// Binary-search initiator: steers a byte comparator to locate its hidden target,
// one comparison per accepted cmp_valid, reporting result, step count and error code.
module byte_search_initiator #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] probe,
  output logic       probe_valid,
  input  logic       cmp_valid,
  input  logic       cmp_equal,
  input  logic       cmp_greater,
  input  logic       cmp_less,
  output logic       busy,
  output logic       done,
  output logic [7:0] found,
  output logic [3:0] steps,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] lo, hi, lo_nx, hi_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic [7:0] found_nx;
  logic [3:0] steps_nx;
  logic [1:0] err_nx;
  logic [8:0] sum, lo_inc, hi_dec;
  logic [7:0] mid;
  logic [1:0] flag_cnt;

  // Midpoint and neighbours kept at 9 bits so the lo>hi exhaustion test cannot wrap.
  assign sum      = {1'b0, lo} + {1'b0, hi};
  assign mid      = sum[8:1];
  assign lo_inc   = {1'b0, mid} + 9'd1;
  assign hi_dec   = {1'b0, mid} - 9'd1;
  assign flag_cnt = {1'b0, cmp_equal} + {1'b0, cmp_greater} + {1'b0, cmp_less};

  assign probe       = (state == PROBE) ? mid : 8'd0;
  assign probe_valid = (state == PROBE);
  assign busy        = (state == PROBE);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lo       <= 8'd0;
      hi       <= 8'd255;
      wait_cnt <= 8'd0;
      found    <= 8'd0;
      steps    <= 4'd0;
      err_code <= 2'd0;
    end else begin
      state    <= state_nx;
      lo       <= lo_nx;
      hi       <= hi_nx;
      wait_cnt <= wait_nx;
      found    <= found_nx;
      steps    <= steps_nx;
      err_code <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lo_nx    = lo;
    hi_nx    = hi;
    wait_nx  = wait_cnt;
    found_nx = found;
    steps_nx = steps;
    err_nx   = err_code;
    case (state)
      IDLE: begin
        if (start) begin
          lo_nx    = 8'd0;
          hi_nx    = 8'd255;
          wait_nx  = 8'd0;
          found_nx = 8'd0;
          steps_nx = 4'd0;
          err_nx   = 2'd0;
          state_nx = PROBE;
        end
      end
      PROBE: begin
        if (cmp_valid) begin
          steps_nx = steps + 4'd1;
          wait_nx  = 8'd0;
          // Malformed flag sets outrank everything else.
          if (flag_cnt != 2'd1) begin
            err_nx   = 2'd1;
            state_nx = DONE;
          end else if (cmp_equal) begin
            found_nx = mid;
            err_nx   = 2'd0;
            state_nx = DONE;
          end else if (cmp_greater) begin
            if (mid == 8'd255 || lo_inc > {1'b0, hi}) begin
              err_nx   = 2'd3;
              state_nx = DONE;
            end else begin
              lo_nx = lo_inc[7:0];
            end
          end else begin
            if (mid == 8'd0 || {1'b0, lo} > hi_dec) begin
              err_nx   = 2'd3;
              state_nx = DONE;
            end else begin
              hi_nx = hi_dec[7:0];
            end
          end
        end else begin
          wait_nx = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LAST) begin
            err_nx   = 2'd2;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_byte_search_initiator.sv
// Scoreboard bench for byte_search_initiator: a behavioural comparator answers probes,
// expected probes/results are queued by stimulus and checked by an independent monitor.
module tb_byte_search_initiator;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic       cmp_valid, cmp_equal, cmp_greater, cmp_less;
  logic [7:0] probe, found;
  logic       probe_valid, busy, done;
  logic [3:0] steps;
  logic [1:0] err_code;

  logic [7:0] target;
  int         mode;
  int         phase = 0;
  int         checks = 0;
  int         fails = 0;

  typedef struct {
    int found;
    int steps;
    int err;
  } res_t;

  logic [7:0] exp_probe[$];
  res_t       exp_res[$];

  byte_search_initiator #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .probe(probe), .probe_valid(probe_valid),
    .cmp_valid(cmp_valid), .cmp_equal(cmp_equal),
    .cmp_greater(cmp_greater), .cmp_less(cmp_less),
    .busy(busy), .done(done), .found(found),
    .steps(steps), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) phase <= (phase == 2) ? 0 : phase + 1;

  // Modes: 0 always valid, 1 valid every 3rd cycle, 2 greater+less together, 3 never valid.
  always_comb begin
    cmp_valid   = (mode == 1) ? (phase == 2) : (mode != 3);
    cmp_equal   = (target == probe);
    cmp_greater = (target > probe);
    cmp_less    = (target < probe);
    if (mode == 2) begin
      cmp_equal   = 1'b0;
      cmp_greater = 1'b1;
      cmp_less    = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (probe_valid && cmp_valid) begin
        if (exp_probe.size() == 0) checkOutput("probe_unexpected", int'(probe), -1);
        else checkOutput("probe", int'(probe), int'(exp_probe.pop_front()));
      end else if (probe_valid && mode == 1 && exp_probe.size() > 0) begin
        checkOutput("probe_hold", int'(probe), int'(exp_probe[0]));
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          checkOutput("done_unexpected", 1, 0);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          checkOutput("found", int'(found), r.found);
          checkOutput("steps", int'(steps), r.steps);
          checkOutput("err_code", int'(err_code), r.err);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] tgt, input int md, input int ef,
                               input int es, input int ee, input int exp_busy);
    res_t r;
    int   busy_cycles;
    bit   seen;
    r.found = ef;
    r.steps = es;
    r.err   = ee;
    exp_res.push_back(r);
    target = tgt;
    mode   = md;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    busy_cycles = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
    if (exp_busy >= 0) checkOutput("busy_cycles", busy_cycles, exp_busy);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] p2[9] = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    logic [7:0] p3[8] = '{127, 63, 31, 15, 7, 3, 1, 0};
    logic [7:0] p4[8] = '{127, 191, 223, 207, 199, 203, 201, 200};
    logic [7:0] p6[4] = '{127, 63, 95, 111};
    logic [7:0] p7[7] = '{127, 63, 31, 15, 7, 11, 9};
    bit         hit;

    rst_n = 1'b0;
    start = 1'b0;
    target = 8'd0;
    mode = 0;
    #1;
    checkOutput("rst_probe", int'(probe), 0);
    checkOutput("rst_probe_valid", int'(probe_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_found", int'(found), 0);
    checkOutput("rst_steps", int'(steps), 0);
    checkOutput("rst_err", int'(err_code), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    exp_probe.push_back(8'd127);
    applyStimulus(8'd127, 0, 127, 1, 0, 1);

    foreach (p2[i]) exp_probe.push_back(p2[i]);
    applyStimulus(8'd255, 0, 255, 9, 0, 9);

    foreach (p3[i]) exp_probe.push_back(p3[i]);
    applyStimulus(8'd0, 0, 0, 8, 0, 8);

    foreach (p4[i]) exp_probe.push_back(p4[i]);
    applyStimulus(8'd200, 1, 200, 8, 0, -1);

    exp_probe.push_back(8'd127);
    applyStimulus(8'd50, 2, 0, 1, 1, 1);

    applyStimulus(8'd50, 3, 0, 0, 2, 15);

    // Abandon a search mid-flight with reset; no result is queued for it.
    foreach (p6[i]) exp_probe.push_back(p6[i]);
    target = 8'd100;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (probe_valid && probe == 8'd111) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reach_4th_probe", int'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_probe", int'(probe), 0);
    checkOutput("midrst_probe_valid", int'(probe_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_found", int'(found), 0);
    checkOutput("midrst_steps", int'(steps), 0);
    checkOutput("midrst_err", int'(err_code), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checkOutput("post_rst_no_done", int'(done), 0);
    end

    foreach (p7[i]) exp_probe.push_back(p7[i]);
    applyStimulus(8'd9, 0, 9, 7, 0, 7);

    repeat (3) @(negedge clk);
    checkOutput("probe_queue_empty", exp_probe.size(), 0);
    checkOutput("result_queue_empty", exp_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
